// File: rtl/ibus_responder.sv
// Instruction-bus responder: serves fetches from a one-doubleword buffer and
// falls back to a single-beat cbus read on a miss.
package ibus_pkg;
  typedef logic [2:0] msize_t;
  typedef logic [3:0] mlen_t;
  typedef logic [1:0] axi_burst_t;

  localparam msize_t     MSIZE8          = 3'd3;
  localparam mlen_t      MLEN1           = 4'd0;
  localparam axi_burst_t AXI_BURST_FIXED = 2'd0;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    mlen_t       len;
    axi_burst_t  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;
endpackage

module ibus_responder
  import ibus_pkg::*;
#(
  parameter bit HIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp,
  input  logic       flush
);

  typedef enum logic [1:0] {IDLE, MISS, RESP} state_t;

  state_t      state_reg, state_next;
  logic        buf_valid_reg, buf_valid_next;
  logic [60:0] buf_tag_reg, buf_tag_next;
  logic [63:0] buf_data_reg, buf_data_next;
  logic [60:0] pend_tag_reg, pend_tag_next;
  logic        drop_reg, drop_next;

  logic hit;
  logic fill_done;

  // A flush in the same cycle as a would-be hit forces the miss path.
  assign hit       = HIT_EN && buf_valid_reg && !flush && (buf_tag_reg == ireq.addr[63:3]);
  assign fill_done = cresp.ready && cresp.last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      buf_valid_reg <= 1'b0;
      buf_tag_reg   <= '0;
      buf_data_reg  <= '0;
      pend_tag_reg  <= '0;
      drop_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      buf_valid_reg <= buf_valid_next;
      buf_tag_reg   <= buf_tag_next;
      buf_data_reg  <= buf_data_next;
      pend_tag_reg  <= pend_tag_next;
      drop_reg      <= drop_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    buf_valid_next = buf_valid_reg && !flush;
    buf_tag_next   = buf_tag_reg;
    buf_data_next  = buf_data_reg;
    pend_tag_next  = pend_tag_reg;
    drop_next      = drop_reg;
    iresp          = '0;
    creq           = '0;

    unique case (state_reg)
      IDLE: begin
        if (ireq.valid) begin
          if (hit) begin
            state_next = RESP;
          end else begin
            pend_tag_next = ireq.addr[63:3];
            state_next    = MISS;
          end
        end
      end

      MISS: begin
        creq.valid = 1'b1;
        creq.size  = MSIZE8;
        creq.addr  = {pend_tag_reg, 3'b000};
        creq.len   = MLEN1;
        creq.burst = AXI_BURST_FIXED;
        if (fill_done) begin
          // The fill always lands in the buffer; a flush seen during the read
          // only keeps it from being marked valid.
          buf_data_next  = cresp.data;
          buf_tag_next   = pend_tag_reg;
          buf_valid_next = !drop_reg && !flush;
          drop_next      = 1'b0;
          if (ireq.valid && (ireq.addr[63:3] == pend_tag_reg)) begin
            state_next = RESP;
          end else begin
            state_next = IDLE;
          end
        end else if (flush) begin
          drop_next = 1'b1;
        end
      end

      RESP: begin
        iresp.addr_ok = 1'b1;
        iresp.data_ok = 1'b1;
        iresp.data    = buf_data_reg;
        state_next    = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ibus_responder.sv
// Randomised bench for ibus_responder: one HIT_EN=1 and one HIT_EN=0 instance,
// each checked against a transaction-level buffer model and a cbus memory model.
module tb_ibus_responder;
  import ibus_pkg::*;

  logic       clk = 1'b0;
  logic       rst_a   [2];
  logic       flush_a [2];
  ibus_req_t  ireq    [2];
  ibus_resp_t iresp   [2];
  cbus_req_t  creq    [2];
  cbus_resp_t cresp   [2];

  int n_checks = 0;
  int n_errors = 0;

  // cbus memory model state: latency in cycles after creq.valid, reads served
  int lat   [2] = '{2, 2};
  int reads [2] = '{0, 0};
  int wcnt  [2] = '{0, 0};
  bit fired [2] = '{1'b0, 1'b0};

  // reference buffer model
  bit          hit_en  [2] = '{1'b1, 1'b0};
  bit          m_valid [2] = '{1'b0, 1'b0};
  logic [60:0] m_tag   [2];
  logic [63:0] m_data  [2];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    ibus_responder #(.HIT_EN(gi == 0)) dut (
      .clk   (clk),
      .rst   (rst_a[gi]),
      .ireq  (ireq[gi]),
      .iresp (iresp[gi]),
      .creq  (creq[gi]),
      .cresp (cresp[gi]),
      .flush (flush_a[gi])
    );
  end

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    if (a == 64'h0000_0000_8000_0000) return 64'h0000_0013_0000_0093;
    return {a[31:0] ^ 32'hdead_beef, a[63:32] ^ a[31:0] ^ 32'h0bad_f00d};
  endfunction

  function automatic logic [63:0] ctl_of(input cbus_req_t r);
    return 64'({r.valid, r.is_write, r.size, r.strobe, r.len, r.burst});
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory answers each read once, lat[k] cycles after creq.valid first shows.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      cresp[k] = '0;
      if (!creq[k].valid) begin
        wcnt[k]  = 0;
        fired[k] = 1'b0;
      end else if (!fired[k]) begin
        if (wcnt[k] == lat[k]) begin
          cresp[k].ready = 1'b1;
          cresp[k].last  = 1'b1;
          cresp[k].data  = mem_word(creq[k].addr);
          fired[k]       = 1'b1;
          reads[k]++;
        end else begin
          wcnt[k]++;
        end
      end
    end
  end

  // flush_cyc: cycle index (1 = request-decision cycle) in which flush is high.
  // abort_cyc: first cycle in which ireq.valid is dropped (0 = never).
  task automatic fetch(input int k, input logic [63:0] addr, input int flush_cyc, input int abort_cyc);
    logic [60:0] tag;
    logic [63:0] got_data;
    bit exp_hit, got_ok, got_creq, overlap;
    int n, r0, ok_n;
    tag      = addr[63:3];
    exp_hit  = hit_en[k] && m_valid[k] && (m_tag[k] == tag) && (flush_cyc != 1);
    r0       = reads[k];
    got_ok   = 1'b0;
    got_creq = 1'b0;
    overlap  = 1'b0;
    got_data = '0;
    ok_n     = 0;
    n        = 0;
    @(posedge clk); #1;
    ireq[k].valid = 1'b1;
    ireq[k].addr  = addr;
    flush_a[k]    = (flush_cyc == 1);
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (creq[k].valid && !got_creq) begin
        got_creq = 1'b1;
        check("creq_addr", creq[k].addr, {tag, 3'b000});
        check("creq_ctl", ctl_of(creq[k]), 64'({1'b1, 1'b0, MSIZE8, 8'h00, MLEN1, AXI_BURST_FIXED}));
        check("creq_data", creq[k].data, 64'd0);
      end
      if (creq[k].valid && iresp[k].data_ok) overlap = 1'b1;
      if (iresp[k].data_ok && !got_ok) begin
        got_ok   = 1'b1;
        ok_n     = n;
        got_data = iresp[k].data;
        check("addr_ok", 64'(iresp[k].addr_ok), 64'd1);
      end
      if (got_ok && abort_cyc == 0) break;
      if (abort_cyc != 0 && n >= lat[k] + 5) break;
      @(posedge clk); #1;
      flush_a[k] = (flush_cyc == n + 1);
      if (abort_cyc != 0 && n + 1 >= abort_cyc) ireq[k].valid = 1'b0;
    end
    @(posedge clk); #1;
    ireq[k].valid = 1'b0;
    flush_a[k]    = 1'b0;
    @(negedge clk);
    check("ok_one_cycle", 64'(iresp[k].data_ok), 64'd0);
    check("idle_outputs_zero", 64'((iresp[k] == '0) && (creq[k] == '0)), 64'd1);
    check("no_ok_with_creq", 64'(overlap), 64'd0);
    if (abort_cyc != 0) begin
      check("abort_no_resp", 64'(got_ok), 64'd0);
      check("abort_reads", 64'(reads[k] - r0), 64'd1);
    end else begin
      check("resp_seen", 64'(got_ok), 64'd1);
      check("resp_data", got_data, exp_hit ? m_data[k] : mem_word({tag, 3'b000}));
      check("resp_latency", 64'(ok_n), exp_hit ? 64'd2 : 64'(lat[k] + 3));
      check("cbus_reads", 64'(reads[k] - r0), exp_hit ? 64'd0 : 64'd1);
      check("creq_seen", 64'(got_creq), exp_hit ? 64'd0 : 64'd1);
    end
    if (!exp_hit) begin
      m_tag[k]   = tag;
      m_data[k]  = mem_word({tag, 3'b000});
      m_valid[k] = !(flush_cyc >= 2);
    end
    $display("fetch k=%0d addr=%h hit=%0d flush=%0d abort=%0d lat=%0d data=%h",
             k, addr, exp_hit, flush_cyc, abort_cyc, lat[k], got_data);
  endtask

  task automatic rst_mid_miss(input int k, input logic [63:0] addr);
    int n;
    n = 0;
    lat[k] = 3;
    @(posedge clk); #1;
    ireq[k].valid = 1'b1;
    ireq[k].addr  = addr;
    @(negedge clk);
    while (n < 10 && !creq[k].valid) begin
      @(negedge clk);
      n++;
    end
    check("rst_creq_before", 64'(creq[k].valid), 64'd1);
    @(posedge clk); #1;
    rst_a[k]      = 1'b1;
    ireq[k].valid = 1'b0;
    @(posedge clk); #1;
    rst_a[k] = 1'b0;
    @(negedge clk);
    check("rst_creq_valid", 64'(creq[k].valid), 64'd0);
    check("rst_data_ok", 64'(iresp[k].data_ok), 64'd0);
    m_valid[k] = 1'b0;
    $display("reset mid-miss k=%0d addr=%h", k, addr);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_a[k]   = 1'b1;
      flush_a[k] = 1'b0;
      ireq[k]    = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) rst_a[k] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("reset_iresp", 64'(iresp[k] == '0), 64'd1);
      check("reset_creq", 64'(creq[k] == '0), 64'd1);
    end

    // directed sequence on the buffered instance
    lat[0] = 2;
    fetch(0, 64'h8000_0000, 0, 0);
    fetch(0, 64'h8000_0004, 0, 0);
    fetch(0, 64'h8000_0008, 0, 0);
    fetch(0, 64'h8000_0010, 3, 0);
    fetch(0, 64'h8000_0010, 0, 0);
    fetch(0, 64'h8000_0018, 0, 3);
    fetch(0, 64'h8000_001c, 0, 0);
    fetch(0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0);
    fetch(0, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0);
    fetch(0, 64'hFFFF_FFFF_FFFF_FFF8, 1, 0);
    fetch(0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0);
    fetch(0, 64'h8000_0020, 4, 0);
    fetch(0, 64'h8000_0024, 0, 0);
    rst_mid_miss(0, 64'h8000_0028);
    fetch(0, 64'h8000_0020, 0, 0);

    // unbuffered instance
    lat[1] = 2;
    fetch(1, 64'h8000_0000, 0, 0);
    fetch(1, 64'h8000_0004, 0, 0);
    rst_mid_miss(1, 64'h8000_0008);
    fetch(1, 64'h8000_0008, 0, 0);

    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 60; i++) begin
        logic [63:0] a;
        int mode;
        bit eh;
        if (i % 13 == 5) a = 64'hFFFF_FFFF_FFFF_FFF8 | 64'($urandom_range(0, 1) << 2);
        else             a = 64'h8000_0000 + 64'(4 * $urandom_range(0, 11));
        lat[k] = $urandom_range(0, 3);
        eh     = hit_en[k] && m_valid[k] && (m_tag[k] == a[63:3]);
        mode   = $urandom_range(0, 5);
        if (mode == 0)             fetch(k, a, 1, 0);
        else if (mode == 1 && !eh) fetch(k, a, $urandom_range(2, 2 + lat[k]), 0);
        else if (mode == 2 && !eh) fetch(k, a, 0, $urandom_range(2, 2 + lat[k]));
        else                       fetch(k, a, 0, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ibus_responder.md
# ibus_responder

Responder end of the instruction bus. It accepts fetch-side `ibus_req_t` requests, serves them from a one-entry 64-bit doubleword buffer when possible, and otherwise issues a single-beat `cbus_req_t` read to memory. Its output is an `ibus_resp_t` carrying the full aligned doubleword; the fetch stage selects the 32-bit half using `pc[2]`. It sits between the fetch stage and the cbus arbiter, so back-to-back fetches of `pc` and `pc+4` within one doubleword cost no memory traffic.

## Interface
Parameters:
- `HIT_EN`, default 1: when 0, the buffer is never consulted and every request misses.

Ports:
- `clk`: input, 1 bit. Single clock; all state updates on its rising edge.
- `rst`: input, 1 bit. Synchronous, active-high reset.
- `ireq`: input, `ibus_req_t`. Uses `valid` and `addr` (u64).
- `iresp`: output, `ibus_resp_t`. Drives `addr_ok`, `data_ok` and `data` (u64).
- `creq`: output, `cbus_req_t`. Drives `valid`, `is_write`, `size`, `addr`, `strobe`, `data`, `len` and `burst`.
- `cresp`: input, `cbus_resp_t`. Uses `ready`, `last` and `data` (u64).
- `flush`: input, 1 bit. Invalidates the buffer (redirect or fence.i).

## Operation
- State: `buf_valid`, `buf_tag[60:0]` (`addr[63:3]`), `buf_data[63:0]`, `drop` flag, and an FSM with states IDLE, MISS, RESP.
- Requester protocol: `ireq.valid` and `ireq.addr` are held stable until `iresp.data_ok`. The responder does not depend on this for correctness (see abort below).
- IDLE:
  - If `ireq.valid` and `HIT_EN` and `buf_valid` and `buf_tag == ireq.addr[63:3]` (hit): next state RESP.
  - If `ireq.valid` and the hit condition fails (miss): latch `addr[63:3]` as the pending tag; next state MISS.
  - Otherwise stay in IDLE.
- MISS:
  - `creq.valid=1`, `is_write=0`, `size=MSIZE8`, `addr={tag,3'b000}`, `strobe=0`, `data=0`, `len=MLEN1`, `burst=AXI_BURST_FIXED`.
  - On `cresp.ready & cresp.last`: write `cresp.data` into `buf_data` and the pending tag into `buf_tag`.
    - Set `buf_valid` to 1, or to 0 if `drop` is set.
    - Clear `drop`.
    - Next state: RESP if `ireq.valid` is still 1 and `ireq.addr[63:3]` equals the pending tag; otherwise IDLE (abort, no response).
  - A started cbus read is never abandoned.
- RESP:
  - Outputs `iresp.addr_ok=1`, `iresp.data_ok=1`, `iresp.data=buf_data` for exactly one cycle.
  - Next state is IDLE unconditionally.
- `flush`:
  - Clears `buf_valid` in every state.
  - If `flush` is asserted in MISS (and it is not the completion cycle), set `drop`, so the in-flight fill returns data to the requester but does not validate the buffer.
  - If `flush` coincides with the fill-completion cycle, `buf_valid` ends 0.
- Outside RESP: `iresp` is all zero. Outside MISS: `creq` is all zero.

## Timing
- Reset: state IDLE. `buf_valid=0`, `drop=0`, `buf_tag=0`, `buf_data=0`. `iresp` all zero, `creq` all zero.
- `rst` overrides everything, including an in-flight MISS. `creq.valid` drops the next cycle; the arbiter owns any cbus cleanup.
- Hit latency: request seen in IDLE at cycle N gives `data_ok` at N+1. Back-to-back hits give one response every 2 cycles.
- Miss latency: request at cycle N puts `creq.valid` at N+1. With `cresp.last` at cycle M, `data_ok` is at M+1.
- `data_ok` never asserts in the same cycle as `creq.valid`.
- Simultaneous `flush` and hit in IDLE: `flush` wins. The request is treated as a miss and goes to MISS.
- Tag compare uses the full 61 bits. No wrap-around special case: `addr=0xFFFF_FFFF_FFFF_FFFC` maps to tag `0x1FFF_FFFF_FFFF_FFFF` like any other address.

## Test plan
- Reset, then `ireq.valid=1`, `addr=0x8000_0000`, with `cresp` returning `0x0000_0013_0000_0093` two cycles after `creq.valid` → `creq.addr=0x8000_0000`, `size=MSIZE8`, `len=MLEN1`. `data_ok` is 1 for one cycle with `data=0x0000_0013_0000_0093`.
- Follow with `addr=0x8000_0004` → no `creq.valid`. `data_ok` one cycle after the request, same data (hit).
- Request `0x8000_0008` after a hit on `0x8000_0000` → miss. `creq.addr=0x8000_0008`, and the buffer is replaced.
- Assert `flush` for one cycle mid-MISS on `0x8000_0010` → response is still delivered. A re-request of `0x8000_0010` misses again (`creq.valid` reasserts).
- Drop `ireq.valid` during MISS → cbus read completes, no `data_ok`, FSM returns to IDLE. An immediate request to the same address hits.
- `HIT_EN=0`: two sequential requests to `0x8000_0000` and `0x8000_0004` → two cbus reads. Assert `rst` mid-MISS → next cycle `creq.valid=0`, `iresp.data_ok=0`, `buf_valid=0`.
